ram_dp_be_init: RTL and testbench



---
 rtl/ram_dp_be_init.sv | 200 ++++++++++++++++++++
 tb/tb_ram_dp_be_init.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_be_init.sv
// ram_dp_be_init: 1W/1R synchronous RAM with byte enables and a post-reset clear.
// Build option: RAM_WR_BYPASS_EN forwards same-cycle write lanes to a colliding read.
//
// Ports:
//   clk        rising-edge clock for all logic
//   rst_n      synchronous active-low reset
//   wr_cs      write chip select
//   wr_we      write enable
//   wr_be      byte-lane enables (NB bits)
//   wr_addr    write address
//   wr_data    write data
//   rd_cs      read chip select
//   rd_oe      read output enable
//   rd_addr    read address
//   rd_data    registered read data, holds between reads
//   rd_valid   one-cycle pulse with each new rd_data
//   init_busy  clear sequence running, all accesses ignored
module ram_dp_be_init #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_cs,
  input  logic                             wr_we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             rd_cs,
  input  logic                             rd_oe,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             init_busy
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
      $error("ram_dp_be_init: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bw
      $error("ram_dp_be_init: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
  endgenerate

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    clr_we;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_acc;
  logic                    rd_acc;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    out_vld;
  logic [DATA_WIDTH-1:0]   out_data;

  // ---------------- clear sequencer ----------------

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == CLEAR): begin
        if (&clr_cnt) begin
          state_nxt = READY;
        end
      end
      (state == READY): begin
        state_nxt = READY;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  always_comb begin
    init_busy = 1'b1;
    clr_we    = 1'b0;
    unique case (1'b1)
      (state == CLEAR): begin
        init_busy = 1'b1;
        clr_we    = 1'b1;
      end
      (state == READY): begin
        init_busy = 1'b0;
        clr_we    = 1'b0;
      end
      default: begin
        init_busy = 1'b1;
        clr_we    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_cnt <= '0;
    end else if (clr_we) begin
      clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
    end
  end

  // ---------------- write port ----------------

  assign wr_acc = wr_cs & wr_we & ~init_busy;

  // The sequencer owns the array while clearing; rst_n gates it so a
  // reset held across many edges does not advance anything.
  always_ff @(posedge clk) begin
    if (rst_n && clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
            wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // ---------------- read port ----------------

  assign rd_acc = rd_cs & rd_oe & ~init_busy;

  // Array read sees pre-write contents; the bypass build overlays the
  // enabled lanes of a same-cycle write to the same word.
  always_comb begin
    rd_word = mem[rd_addr];
`ifdef RAM_WR_BYPASS_EN
    if (wr_acc && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
            wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
`endif
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  s1_vld;
      logic [DATA_WIDTH-1:0] s1_data;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_vld  <= 1'b0;
          s1_data <= '0;
        end else begin
          s1_vld <= rd_acc;
          if (rd_acc) begin
            s1_data <= rd_word;
          end
        end
      end

      assign out_vld  = s1_vld;
      assign out_data = s1_data;
    end else begin : g_lat1
      assign out_vld  = rd_acc;
      assign out_data = rd_word;
    end
  endgenerate

  // Output register: rd_data only moves when a read completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= out_vld;
      if (out_vld) begin
        rd_data <= out_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_be_init.sv
// tb_ram_dp_be_init: drives latency-1 and latency-2 instances in parallel
// against a word-array reference model with per-latency expected outputs.
module tb_ram_dp_be_init;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_cs, wr_we;
  logic [1:0]  wr_be;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_cs, rd_oe;
  logic [3:0]  rd_addr;

  logic [15:0] rd_data1, rd_data2;
  logic        rd_valid1, rd_valid2;
  logic        busy1, busy2;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [15:0] m_mem [16];
  int          busy_cnt;
  logic        e1_v, p2_v, e2_v;
  logic [15:0] e1_d, p2_d, e2_d;

  always #5 clk = ~clk;

  ram_dp_be_init #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4),
    .BYTE_WIDTH(8), .RD_LATENCY(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .wr_cs(wr_cs), .wr_we(wr_we), .wr_be(wr_be),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_cs(rd_cs), .rd_oe(rd_oe), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1),
    .init_busy(busy1)
  );

  ram_dp_be_init #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4),
    .BYTE_WIDTH(8), .RD_LATENCY(2)
  ) u2 (
    .clk(clk), .rst_n(rst_n),
    .wr_cs(wr_cs), .wr_we(wr_we), .wr_be(wr_be),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_cs(rd_cs), .rd_oe(rd_oe), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2),
    .init_busy(busy2)
  );

  task automatic idle();
    wr_cs = 0; wr_we = 0; wr_be = 0;
    wr_addr = 0; wr_data = 0;
    rd_cs = 0; rd_oe = 0; rd_addr = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d,
                    input logic [1:0] be);
    wr_cs = 1; wr_we = 1; wr_be = be;
    wr_addr = a; wr_data = d;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_cs = 1; rd_oe = 1; rd_addr = a;
  endtask

  // One clock edge: advance the model from the inputs in force, then
  // leave the sample point 1 ns after the edge.
  task automatic step();
    logic        acc_r, acc_w;
    logic [15:0] w;
    @(posedge clk);
    if (!rst_n) begin
      e1_v = 0; e1_d = 0;
      p2_v = 0; p2_d = 0;
      e2_v = 0; e2_d = 0;
      busy_cnt = 16;
    end else begin
      acc_r = rd_cs && rd_oe && (busy_cnt == 0);
      acc_w = wr_cs && wr_we && (busy_cnt == 0);
      w = m_mem[rd_addr];
`ifdef RAM_WR_BYPASS_EN
      if (acc_w && wr_addr == rd_addr)
        for (int b = 0; b < 2; b++)
          if (wr_be[b]) w[8*b +: 8] = wr_data[8*b +: 8];
`endif
      e2_v = p2_v;
      if (p2_v) e2_d = p2_d;
      p2_v = acc_r;
      if (acc_r) p2_d = w;
      e1_v = acc_r;
      if (acc_r) e1_d = w;
      if (acc_w)
        for (int b = 0; b < 2; b++)
          if (wr_be[b]) m_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
      if (busy_cnt > 0) begin
        m_mem[16 - busy_cnt] = 16'h0;
        busy_cnt--;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    step();
    step();
    checks++;
    if (rd_valid1 !== 0 || rd_valid2 !== 0) begin
      errors++;
      $display("FAIL reset_valid: got %b/%b want 0/0", rd_valid1, rd_valid2);
    end
    checks++;
    if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h want 0000/0000", rd_data1, rd_data2);
    end
    checks++;
    if (busy1 !== 1 || busy2 !== 1) begin
      errors++;
      $display("FAIL reset_busy: got %b/%b want 1/1", busy1, busy2);
    end
  endtask

  task automatic test_clear();
    int n = 0;
    int v1 = 0;
    int v2 = 0;
    rst_n = 1;
    wr(4'd3, 16'hBEEF, 2'b11);
    rd(4'd3);
    while (busy1 === 1 && n < 40) begin
      n++;
      step();
      checks++;
      if (rd_valid1 !== 0 || rd_valid2 !== 0) begin
        errors++;
        $display("FAIL clear_no_valid: cyc %0d got %b/%b want 0/0",
                 n, rd_valid1, rd_valid2);
      end
      checks++;
      if (busy2 !== (busy_cnt > 0)) begin
        errors++;
        $display("FAIL clear_busy2: cyc %0d got %b want %b",
                 n, busy2, busy_cnt > 0);
      end
    end
    idle();
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL clear_len: got %0d busy cycles want 16", n);
    end
    for (int a = 0; a < 18; a++) begin
      if (a < 16) rd(4'(a));
      else idle();
      step();
      if (rd_valid1 === 1) v1++;
      if (rd_valid2 === 1) v2++;
      checks++;
      if (rd_valid1 !== e1_v || rd_data1 !== e1_d ||
          rd_valid2 !== e2_v || rd_data2 !== e2_d) begin
        errors++;
        $display("FAIL clear_sweep: a %0d got %b:%h %b:%h want %b:%h %b:%h",
                 a, rd_valid1, rd_data1, rd_valid2, rd_data2,
                 e1_v, e1_d, e2_v, e2_d);
      end
      checks++;
      if (rd_valid1 === 1 && rd_data1 !== 16'h0) begin
        errors++;
        $display("FAIL clear_zero: a %0d got %h want 0000", a, rd_data1);
      end
    end
    checks++;
    if (v1 != 16 || v2 != 16) begin
      errors++;
      $display("FAIL clear_pulses: got %0d/%0d want 16/16", v1, v2);
    end
  endtask

  task automatic test_byte_enable();
    wr(4'd5, 16'hAABB, 2'b11);
    step();
    wr(4'd5, 16'h1122, 2'b01);
    step();
    idle();
    rd(4'd5);
    step();
    idle();
    checks++;
    if (rd_valid1 !== 1 || rd_data1 !== 16'hAA22) begin
      errors++;
      $display("FAIL be_lat1: got %b:%h want 1:aa22", rd_valid1, rd_data1);
    end
    step();
    checks++;
    if (rd_valid2 !== 1 || rd_data2 !== 16'hAA22) begin
      errors++;
      $display("FAIL be_lat2: got %b:%h want 1:aa22", rd_valid2, rd_data2);
    end
    step();
  endtask

  task automatic test_latency();
    logic        v1 [5] = '{1, 1, 1, 0, 0};
    logic        v2 [5] = '{0, 1, 1, 1, 0};
    logic [15:0] d1 [5] = '{16'h0101, 16'h0202, 16'h0303,
                            16'h0303, 16'h0303};
    logic [15:0] d2 [5] = '{16'hAA22, 16'h0101, 16'h0202,
                            16'h0303, 16'h0303};
    for (int a = 1; a <= 3; a++) begin
      wr(4'(a), {2{8'(a)}}, 2'b11);
      step();
    end
    idle();
    step();
    for (int s = 0; s < 5; s++) begin
      if (s < 3) rd(4'(s + 1));
      else idle();
      step();
      checks++;
      if (rd_valid1 !== v1[s] || rd_data1 !== d1[s]) begin
        errors++;
        $display("FAIL lat1_seq: s %0d got %b:%h want %b:%h",
                 s, rd_valid1, rd_data1, v1[s], d1[s]);
      end
      checks++;
      if (rd_valid2 !== v2[s] || rd_data2 !== d2[s]) begin
        errors++;
        $display("FAIL lat2_seq: s %0d got %b:%h want %b:%h",
                 s, rd_valid2, rd_data2, v2[s], d2[s]);
      end
    end
  endtask

  task automatic test_collision();
    logic [15:0] col;
`ifdef RAM_WR_BYPASS_EN
    col = 16'hAB34;
`else
    col = 16'h1234;
`endif
    wr(4'd7, 16'h1234, 2'b11);
    step();
    wr(4'd7, 16'hABCD, 2'b10);
    rd(4'd7);
    step();
    idle();
    checks++;
    if (rd_valid1 !== 1 || rd_data1 !== col) begin
      errors++;
      $display("FAIL col_lat1: got %b:%h want 1:%h", rd_valid1, rd_data1, col);
    end
    rd(4'd7);
    step();
    idle();
    checks++;
    if (rd_valid2 !== 1 || rd_data2 !== col) begin
      errors++;
      $display("FAIL col_lat2: got %b:%h want 1:%h", rd_valid2, rd_data2, col);
    end
    checks++;
    if (rd_valid1 !== 1 || rd_data1 !== 16'hAB34) begin
      errors++;
      $display("FAIL col_after1: got %b:%h want 1:ab34", rd_valid1, rd_data1);
    end
    step();
    checks++;
    if (rd_valid2 !== 1 || rd_data2 !== 16'hAB34) begin
      errors++;
      $display("FAIL col_after2: got %b:%h want 1:ab34", rd_valid2, rd_data2);
    end
  endtask

  task automatic test_gating();
    rd_cs = 1; rd_oe = 0; rd_addr = 4'd2;
    step();
    rd_cs = 0; rd_oe = 1;
    step();
    wr_cs = 1; wr_we = 0; wr_be = 2'b11;
    wr_addr = 4'd2; wr_data = 16'hDEAD;
    rd_cs = 0; rd_oe = 0;
    step();
    wr_we = 1; wr_be = 2'b00;
    step();
    wr_cs = 0; wr_be = 2'b11;
    step();
    idle();
    step();
    checks++;
    if (rd_valid1 !== 0 || rd_valid2 !== 0) begin
      errors++;
      $display("FAIL gate_valid: got %b/%b want 0/0", rd_valid1, rd_valid2);
    end
    checks++;
    if (rd_data1 !== 16'hAB34 || rd_data2 !== 16'hAB34) begin
      errors++;
      $display("FAIL gate_hold: got %h/%h want ab34/ab34", rd_data1, rd_data2);
    end
    rd(4'd2);
    step();
    idle();
    step();
    checks++;
    if (rd_data1 !== 16'h0202 || rd_data2 !== 16'h0202) begin
      errors++;
      $display("FAIL gate_nowrite: got %h/%h want 0202/0202",
               rd_data1, rd_data2);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_cs   = 1'($urandom);
      wr_we   = 1'($urandom);
      wr_be   = 2'($urandom);
      wr_addr = 4'($urandom);
      wr_data = 16'($urandom);
      rd_cs   = ($urandom_range(0, 3) != 0);
      rd_oe   = ($urandom_range(0, 3) != 0);
      rd_addr = $urandom_range(0, 1) ? wr_addr : 4'($urandom);
      step();
      checks++;
      if (rd_valid1 !== e1_v || rd_data1 !== e1_d) begin
        errors++;
        $display("FAIL rand_lat1: cyc %0d got %b:%h want %b:%h",
                 c, rd_valid1, rd_data1, e1_v, e1_d);
      end
      checks++;
      if (rd_valid2 !== e2_v || rd_data2 !== e2_d) begin
        errors++;
        $display("FAIL rand_lat2: cyc %0d got %b:%h want %b:%h",
                 c, rd_valid2, rd_data2, e2_v, e2_d);
      end
    end
    idle();
    step();
    step();
  endtask

  task automatic test_reset_inflight();
    int n;
    rd(4'd9);
    step();
    idle();
    rst_n = 0;
    step();
    checks++;
    if (rd_valid2 !== 0 || rd_data2 !== 16'h0 || rd_data1 !== 16'h0) begin
      errors++;
      $display("FAIL rst_flight: got %b:%h d1 %h want 0:0000 d1 0000",
               rd_valid2, rd_data2, rd_data1);
    end
    checks++;
    if (busy1 !== 1 || busy2 !== 1) begin
      errors++;
      $display("FAIL rst_busy: got %b/%b want 1/1", busy1, busy2);
    end
    rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (rd_valid1 !== 0 || rd_valid2 !== 0) begin
        errors++;
        $display("FAIL rst_no_pulse: k %0d got %b/%b want 0/0",
                 k, rd_valid1, rd_valid2);
      end
    end
    rst_n = 0;
    step();
    rst_n = 1;
    n = 0;
    while (busy2 === 1 && n < 40) begin
      n++;
      step();
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL rst_restart: got %0d busy cycles want 16", n);
    end
    rd(4'd9);
    step();
    idle();
    step();
    checks++;
    if (rd_valid2 !== 1 || rd_data2 !== 16'h0 || rd_data1 !== 16'h0) begin
      errors++;
      $display("FAIL rst_recleared: got %b:%h d1 %h want 1:0000 d1 0000",
               rd_valid2, rd_data2, rd_data1);
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++) m_mem[a] = 16'h0;
    busy_cnt = 16;
    e1_v = 0; e1_d = 0;
    p2_v = 0; p2_d = 0;
    e2_v = 0; e2_d = 0;
    rst_n = 0;
    idle();
    test_reset();
    test_clear();
    test_byte_enable();
    test_latency();
    test_collision();
    test_gating();
    test_random();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit, checks %0d", checks);
    $fatal(1);
  end

endmodule
